// File: rtl/line_draw_ctrl_if.sv
// Command and framebuffer-write bundle for the line draw controller.
// master = command source / framebuffer sink, slave = the controller.
interface line_draw_ctrl_if #(
    parameter int ADDR_W = 19
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [15:0]       cmd_x1;
    logic [15:0]       cmd_y1;
    logic [15:0]       cmd_x2;
    logic [15:0]       cmd_y2;
    logic [15:0]       cmd_color;
    logic              fb_wr_valid;
    logic              fb_wr_ready;
    logic [ADDR_W-1:0] fb_addr;
    logic [15:0]       fb_data;

    modport master (
        output cmd_valid, cmd_x1, cmd_y1, cmd_x2, cmd_y2, cmd_color, fb_wr_ready,
        input  cmd_ready, fb_wr_valid, fb_addr, fb_data
    );

    modport slave (
        input  cmd_valid, cmd_x1, cmd_y1, cmd_x2, cmd_y2, cmd_color, fb_wr_ready,
        output cmd_ready, fb_wr_valid, fb_addr, fb_data
    );
endinterface

// File: rtl/line_draw_ctrl.sv
// Sequences an external line engine pixel by pixel and turns each pixel into a
// clipped framebuffer write, with a per-line pixel limit as a runaway guard.
//
// state  | meaning
// IDLE   | waiting for a line command
// LOAD   | dl_calculate pulse, engine loads endpoints
// SETTLE | engine output settles, pixel and address registered
// EMIT   | write (or clip) the registered pixel
// STEP   | dl_get_pixel pulse, engine advances
module line_draw_ctrl #(
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int ADDR_W  = 19,
    parameter int MAX_PIX = 4096
) (
    input  logic        clk,
    input  logic        reset,
    line_draw_ctrl_if.slave bus,
    output logic        dl_calculate,
    output logic        dl_get_pixel,
    output logic [15:0] dl_x1,
    output logic [15:0] dl_y1,
    output logic [15:0] dl_x2,
    output logic [15:0] dl_y2,
    input  logic [15:0] dl_x_o,
    input  logic [15:0] dl_y_o,
    output logic        busy,
    output logic        done,
    output logic        overrun,
    output logic [15:0] pixel_count
);
    localparam int EW = $clog2(MAX_PIX + 1);

    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, EMIT, STEP} state_t;

    state_t            state_q, state_d;
    logic [15:0]       x1_q, y1_q, x2_q, y2_q, color_q;
    logic [15:0]       x1_d, y1_d, x2_d, y2_d, color_d;
    logic [15:0]       px_x_q, px_y_q, px_x_d, px_y_d;
    logic              in_range_q, in_range_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [15:0]       pixel_count_q, pixel_count_d;
    logic [EW-1:0]     emit_cnt_q, emit_cnt_d;
    logic              done_q, done_d;
    logic              overrun_q, overrun_d;
    logic [31:0]       addr_full;
    logic              complete;
    logic              at_end;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            x1_q          <= '0;
            y1_q          <= '0;
            x2_q          <= '0;
            y2_q          <= '0;
            color_q       <= '0;
            px_x_q        <= '0;
            px_y_q        <= '0;
            in_range_q    <= 1'b0;
            fb_addr_q     <= '0;
            pixel_count_q <= '0;
            emit_cnt_q    <= '0;
            done_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            x1_q          <= x1_d;
            y1_q          <= y1_d;
            x2_q          <= x2_d;
            y2_q          <= y2_d;
            color_q       <= color_d;
            px_x_q        <= px_x_d;
            px_y_q        <= px_y_d;
            in_range_q    <= in_range_d;
            fb_addr_q     <= fb_addr_d;
            pixel_count_q <= pixel_count_d;
            emit_cnt_q    <= emit_cnt_d;
            done_q        <= done_d;
            overrun_q     <= overrun_d;
        end
    end

    assign addr_full = 32'(dl_y_o) * 32'(WIDTH) + 32'(dl_x_o);
    assign at_end    = (px_x_q == x2_q) && (px_y_q == y2_q);

    always_comb begin
        state_d         = state_q;
        x1_d            = x1_q;
        y1_d            = y1_q;
        x2_d            = x2_q;
        y2_d            = y2_q;
        color_d         = color_q;
        px_x_d          = px_x_q;
        px_y_d          = px_y_q;
        in_range_d      = in_range_q;
        fb_addr_d       = fb_addr_q;
        pixel_count_d   = pixel_count_q;
        emit_cnt_d      = emit_cnt_q;
        done_d          = 1'b0;
        overrun_d       = overrun_q;
        dl_calculate    = 1'b0;
        dl_get_pixel    = 1'b0;
        bus.fb_wr_valid = 1'b0;
        complete        = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    x1_d          = bus.cmd_x1;
                    y1_d          = bus.cmd_y1;
                    x2_d          = bus.cmd_x2;
                    y2_d          = bus.cmd_y2;
                    color_d       = bus.cmd_color;
                    pixel_count_d = '0;
                    emit_cnt_d    = '0;
                    overrun_d     = 1'b0;
                    state_d       = LOAD;
                end
            end
            LOAD: begin
                dl_calculate = 1'b1;
                state_d      = SETTLE;
            end
            SETTLE: begin
                px_x_d     = dl_x_o;
                px_y_d     = dl_y_o;
                in_range_d = (32'(dl_x_o) < 32'(WIDTH)) && (32'(dl_y_o) < 32'(HEIGHT));
                fb_addr_d  = ADDR_W'(addr_full);
                state_d    = EMIT;
            end
            EMIT: begin
                bus.fb_wr_valid = in_range_q;
                // clipped pixels complete immediately without a write
                complete        = !in_range_q || bus.fb_wr_ready;
                if (complete) begin
                    if (in_range_q && pixel_count_q != 16'hFFFF)
                        pixel_count_d = pixel_count_q + 16'd1;
                    emit_cnt_d = emit_cnt_q + EW'(1);
                    if (at_end) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else if (32'(emit_cnt_q) + 32'd1 >= 32'(MAX_PIX)) begin
                        done_d    = 1'b1;
                        overrun_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        state_d = STEP;
                    end
                end
            end
            STEP: begin
                dl_get_pixel = 1'b1;
                state_d      = SETTLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy          = (state_q != IDLE);
    assign bus.cmd_ready = !busy;
    assign bus.fb_addr   = fb_addr_q;
    assign bus.fb_data   = color_q;
    assign dl_x1         = x1_q;
    assign dl_y1         = y1_q;
    assign dl_x2         = x2_q;
    assign dl_y2         = y2_q;
    assign done          = done_q;
    assign overrun       = overrun_q;
    assign pixel_count   = pixel_count_q;
endmodule

// File: doc/line_draw_ctrl.md
LINE_DRAW_CTRL -- requirements
Module: line_draw_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, 640, framebuffer width in pixels (clip bound for x).
REQ-002 SHALL have parameter HEIGHT, 480, framebuffer height in pixels (clip bound for y).
REQ-003 SHALL have parameter ADDR_W, 19, framebuffer word-address width.
REQ-004 SHALL have parameter MAX_PIX, 4096, per-line pixel limit before forced termination.
REQ-005 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports cmd_valid in 1 / cmd_ready out 1  line-command handshake.
REQ-008 SHALL have ports cmd_x1, cmd_y1, cmd_x2, cmd_y2  in  16 each  line endpoints, unsigned.
REQ-009 SHALL have port cmd_color  in  16  pixel colour.
REQ-010 SHALL have ports dl_calculate out 1, dl_get_pixel out 1  line-engine control pulses.
REQ-011 SHALL have ports dl_x1, dl_y1, dl_x2, dl_y2  out  16 each  endpoints driven to the line engine.
REQ-012 SHALL have ports dl_x_o, dl_y_o  in  16 each  current pixel from the line engine.
REQ-013 SHALL have ports fb_wr_valid out 1 / fb_wr_ready in 1, fb_addr out ADDR_W, fb_data out 16  framebuffer write.
REQ-014 SHALL have ports busy out 1, done out 1, overrun out 1, pixel_count out 16  status.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, SETTLE, EMIT, STEP.
REQ-016 IDLE: cmd_ready=1; on cmd_valid&&cmd_ready SHALL latch endpoints/colour, clear pixel_count and overrun, go to LOAD.
REQ-017 LOAD: dl_calculate=1 for exactly one cycle, then SETTLE.
REQ-018 SETTLE: one cycle with no control pulses; then SHALL register dl_x_o/dl_y_o and go to EMIT.
REQ-019 dl_x1..dl_y2 SHALL equal the latched endpoints in every non-IDLE state and hold their last values in IDLE.
REQ-020 EMIT, in-range pixel (x<WIDTH and y<HEIGHT): fb_wr_valid=1, fb_addr=(y*WIDTH+x) truncated to ADDR_W, fb_data=latched colour.
REQ-021 fb_wr_valid, fb_addr and fb_data SHALL hold stable until fb_wr_ready; the transfer completes on the cycle valid&&ready.
REQ-022 EMIT, out-of-range pixel: fb_wr_valid=0; SHALL treat the pixel as completed in that same cycle (clip, no write).
REQ-023 pixel_count SHALL increment by 1 per completed write; clipped pixels are not counted; it saturates at 16'hFFFF.
REQ-024 On completion, if registered pixel == (x2,y2), SHALL go to IDLE and pulse done for one cycle.
REQ-025 On completion, otherwise SHALL go to STEP: dl_get_pixel=1 for one cycle, then SETTLE.
REQ-026 If the number of emitted pixels (written + clipped) reaches MAX_PIX without reaching (x2,y2), SHALL go to IDLE, pulse done and set overrun, which holds until the next command is accepted.
REQ-027 Latency: command accepted at edge T -> dl_calculate high in cycle T+1 -> first fb_wr_valid in cycle T+3; with fb_wr_ready=1 each pixel SHALL take 3 cycles.
REQ-028 busy SHALL be 1 in every state except IDLE; cmd_ready = !busy, so commands are never accepted while a line is in progress.
REQ-029 dl_calculate and dl_get_pixel SHALL never be high in the same cycle, and neither SHALL be high while fb_wr_valid is 1.

Reset
REQ-030 reset SHALL be sampled on clk: state becomes IDLE on the next edge regardless of current state, including mid-line and mid-handshake.
REQ-031 After reset: cmd_ready=1; busy, done, overrun, dl_calculate, dl_get_pixel and fb_wr_valid = 0; pixel_count, fb_addr, fb_data and dl_x1..dl_y2 = 0.

Verification
REQ-032 Horizontal line (10,50)->(20,50) with fb_wr_ready=1 -> 11 writes, fb_addr 32010..32020 ascending, done pulse, pixel_count=11.
REQ-033 Single point (10,5)->(10,5) -> exactly 1 write at fb_addr 3210, no dl_get_pixel, done 1 cycle later.
REQ-034 Backpressure: hold fb_wr_ready=0 for 5 cycles during a write -> fb_wr_valid, fb_addr and fb_data stable, no dl_get_pixel, resume on ready.
REQ-035 Clipping: (630,10)->(645,10) -> 10 writes, x=630..639 (fb_addr 7030..7039), pixel_count=10, overrun=0, done.
REQ-036 Engine never reaches the endpoint, with MAX_PIX=16 -> 16 emits, then done=1, overrun=1, busy=0.
REQ-037 Reset asserted after the 3rd write of a 50-pixel line -> all outputs at REQ-031 values next cycle; a new command is accepted and runs normally.
